// File: rtl/phase_signal_gen.sv
// phase_signal_gen: two-channel square-wave sample generator with an
// AXIS-style valid/ready output. Channel A sits in the upper half of the
// output word, channel B in the lower half; B leads A by a programmable
// number of samples. Generation runs only while the IAGC status equals
// IAGC_STATUS_INIT.
module phase_signal_gen #(
  parameter int                          IAGC_STATUS_SIZE = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT = 4'b0001,
  parameter int                          AXIS_DATA_SIZE   = 32,
  parameter int                          SAMPLE_DIV       = 4,
  parameter int                          HALF_PERIOD      = 8,
  parameter logic [AXIS_DATA_SIZE/2-1:0] AMPLITUDE        = 16'h4000
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic [7:0]                  i_phase_offset,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [AXIS_DATA_SIZE-1:0]   o_data,
  output logic                        o_sample,
  output logic                        o_overrun
);

  localparam int PERIOD  = 2 * HALF_PERIOD;
  localparam int PHASE_W = $clog2(PERIOD);
  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int CH_W    = AXIS_DATA_SIZE / 2;

  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(PERIOD - 1);
  localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CH_W-1:0]    AMP_NEG   = (~AMPLITUDE) + CH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DIV_W-1:0]        r_div;
  logic [PHASE_W-1:0]      r_phase;
  logic [PHASE_W-1:0]      r_offset_q;
  logic [7:0]              r_offset_src;
  logic                    r_valid;
  logic [AXIS_DATA_SIZE-1:0] r_data;
  logic                    r_sample;
  logic                    r_overrun;

  logic                    w_enable;
  logic                    w_slot;
  logic [PHASE_W-1:0]      w_offset_clamped;
  logic [PHASE_W-1:0]      w_phase_b;
  logic [AXIS_DATA_SIZE-1:0] w_word;

  // Square-wave level for a phase position: positive first half, negative second.
  function automatic logic [CH_W-1:0] level_of(input logic [PHASE_W-1:0] ph);
    logic [CH_W-1:0] lvl;
    if (32'(ph) < HALF_PERIOD) begin
      lvl = AMPLITUDE;
    end else begin
      lvl = AMP_NEG;
    end
    return lvl;
  endfunction

  // Modular addition of two phase positions within one period.
  function automatic logic [PHASE_W-1:0] phase_add(input logic [PHASE_W-1:0] a,
                                                   input logic [PHASE_W-1:0] b);
    logic [PHASE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PHASE_W + 1)'(PERIOD)) begin
      s = s - (PHASE_W + 1)'(PERIOD);
    end else begin
      s = s;
    end
    return s[PHASE_W-1:0];
  endfunction

  assign w_enable = (i_iagc_status == IAGC_STATUS_INIT);

  // Offsets beyond one period are pinned to the last phase position.
  assign w_offset_clamped = ({24'd0, i_phase_offset} > 32'(PERIOD - 1)) ?
                            PHASE_MAX : PHASE_W'(i_phase_offset);

  assign w_phase_b = phase_add(r_phase, r_offset_q);
  assign w_word    = {level_of(r_phase), level_of(w_phase_b)};

  // A slot only counts while the FSM remains in RUN on this edge.
  assign w_slot = (r_state == S_RUN) && (w_state_next == S_RUN) && (r_div == DIV_MAX);

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; losing INIT status always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_enable) w_state_next = S_ALIGN;
        else          w_state_next = S_IDLE;
      end
      S_ALIGN: begin
        if (w_enable) w_state_next = S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (!w_enable)                            w_state_next = S_IDLE;
        else if (i_phase_offset != r_offset_src) w_state_next = S_ALIGN;
        else                                      w_state_next = S_RUN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: divider, phase counter, offset latch and output handshake.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div        <= '0;
      r_phase      <= '0;
      r_offset_q   <= '0;
      r_offset_src <= 8'd0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_sample     <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      if (w_state_next == S_IDLE) begin
        // Idle (or dropping into it): no word on the bus, data parked at zero.
        r_valid <= 1'b0;
        r_data  <= '0;
        r_div   <= '0;
        r_phase <= '0;
      end else if (r_state == S_IDLE) begin
        // Fresh enable: a new generation session starts with a clean overrun flag.
        r_overrun <= 1'b0;
        r_valid   <= 1'b0;
        r_div     <= '0;
        r_phase   <= '0;
      end else if (r_state == S_ALIGN) begin
        r_div        <= '0;
        r_phase      <= '0;
        r_offset_q   <= w_offset_clamped;
        r_offset_src <= i_phase_offset;
        r_valid      <= 1'b0;
      end else if (w_state_next != S_RUN) begin
        // Offset changed: realign, discarding any pending word.
        r_valid <= 1'b0;
      end else begin
        if (r_div == DIV_MAX) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
        if (w_slot) begin
          if (r_phase == PHASE_MAX) begin
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + PHASE_W'(1);
          end
          if (!r_valid || i_ready) begin
            r_data   <= w_word;
            r_valid  <= 1'b1;
            r_sample <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else if (r_valid && i_ready) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= r_valid;
        end
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_sample  = r_sample;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_phase_signal_gen.sv
// Self-checking bench for phase_signal_gen (default parameters).
// A slot-level reference model predicts every output on every cycle; a
// vector table and short directed sequences pin down the documented words.
module tb_phase_signal_gen;

  localparam logic [3:0] INIT     = 4'b0001;
  localparam int         SDIV     = 4;
  localparam int         HALF     = 8;
  localparam int         PER      = 16;
  localparam logic [15:0] POS     = 16'h4000;
  localparam logic [15:0] NEG     = 16'hC000;
  localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  status;
  logic [7:0]  offset;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic        sample;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_mode = M_IDLE;
  int          m_cnt  = 0;
  int          m_k    = 0;
  int          m_off  = 0;
  logic [7:0]  m_src  = 8'd0;
  logic        m_valid = 1'b0;
  logic        m_sample = 1'b0;
  logic        m_over = 1'b0;
  logic [31:0] m_data = 32'd0;

  typedef struct {
    logic [7:0]  off;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  phase_signal_gen dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_iagc_status  (status),
    .i_phase_offset (offset),
    .i_ready        (ready),
    .o_valid        (valid),
    .o_data         (data),
    .o_sample       (sample),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lvl(input int ph);
    return (ph < HALF) ? POS : NEG;
  endfunction

  // Sample word for slot k at a given (already clamped) offset.
  function automatic logic [31:0] word_for(input int k, input int off);
    return {lvl(k % PER), lvl((k + off) % PER)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_k = 0; m_off = 0; m_src = 8'd0;
    m_valid = 1'b0; m_sample = 1'b0; m_over = 1'b0; m_data = 32'd0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic en;
    logic slot;
    if (!rst_n) begin
      model_reset();
      return;
    end
    en = (status == INIT);
    m_sample = 1'b0;
    case (m_mode)
      M_IDLE: begin
        m_valid = 1'b0;
        m_data  = 32'd0;
        if (en) begin
          m_mode = M_ALIGN;
          m_over = 1'b0;
        end
      end
      M_ALIGN: begin
        m_valid = 1'b0;
        if (!en) begin
          m_mode = M_IDLE;
          m_data = 32'd0;
        end else begin
          m_off  = (int'(offset) > PER - 1) ? PER - 1 : int'(offset);
          m_src  = offset;
          m_cnt  = 0;
          m_k    = 0;
          m_mode = M_RUN;
        end
      end
      default: begin
        if (!en) begin
          m_mode  = M_IDLE;
          m_valid = 1'b0;
          m_data  = 32'd0;
        end else if (offset != m_src) begin
          m_mode  = M_ALIGN;
          m_valid = 1'b0;
        end else begin
          slot  = ((m_cnt % SDIV) == SDIV - 1);
          m_cnt = m_cnt + 1;
          if (slot) begin
            if (!m_valid || ready) begin
              m_data   = word_for(m_k, m_off);
              m_valid  = 1'b1;
              m_sample = 1'b1;
            end else begin
              m_over = 1'b1;
            end
            m_k = m_k + 1;
          end else if (m_valid && ready) begin
            m_valid = 1'b0;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", {29'd0, valid, sample, overrun, data},
                   {29'd0, m_valid, m_sample, m_over, m_data});
  endtask

  task automatic go_idle();
    status = 4'b0000;
    tick();
    tick();
  endtask

  // Wait for the idx-th new word; lat = ticks taken, -1 on timeout.
  task automatic wait_word(input int idx, output logic [31:0] w, output int lat);
    int seen;
    seen = 0;
    lat  = 0;
    w    = 32'd0;
    for (int c = 0; c < 400; c++) begin
      tick();
      lat++;
      if (sample) begin
        if (seen == idx) begin
          w = data;
          return;
        end
        seen++;
      end
    end
    lat = -1;
  endtask

  initial begin
    logic [31:0] w;
    int          lat;

    vt[0] = '{off: 8'd0,   idx: 0,  exp: 32'h40004000};
    vt[1] = '{off: 8'd0,   idx: 7,  exp: 32'h40004000};
    vt[2] = '{off: 8'd0,   idx: 8,  exp: 32'hC000C000};
    vt[3] = '{off: 8'd0,   idx: 15, exp: 32'hC000C000};
    vt[4] = '{off: 8'd0,   idx: 16, exp: 32'h40004000};
    vt[5] = '{off: 8'd8,   idx: 0,  exp: 32'h4000C000};
    vt[6] = '{off: 8'd8,   idx: 8,  exp: 32'hC0004000};
    vt[7] = '{off: 8'd4,   idx: 0,  exp: 32'h40004000};
    vt[8] = '{off: 8'd4,   idx: 4,  exp: 32'h4000C000};
    vt[9] = '{off: 8'd200, idx: 1,  exp: 32'h40004000};

    // reset state
    rst_n = 1'b0; status = 4'b0000; offset = 8'd0; ready = 1'b1;
    #3;
    check("reset_outputs", {29'd0, valid, sample, overrun, data}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // vector table: documented words, first-word latency of 1+1+SAMPLE_DIV edges
    for (int i = 0; i < 10; i++) begin
      go_idle();
      offset = vt[i].off;
      ready  = 1'b1;
      status = INIT;
      wait_word(vt[i].idx, w, lat);
      check("vec_word", {32'd0, w}, {32'd0, vt[i].exp});
      if (vt[i].idx == 0) check("first_latency", 64'(lat), 64'd6);
    end

    // clamped offset: first word
    go_idle();
    offset = 8'd200;
    status = INIT;
    wait_word(0, w, lat);
    check("clamp_first", {32'd0, w}, {32'd0, 32'h4000C000});

    // stall: held word stays stable, dropped slot raises overrun
    go_idle();
    offset = 8'd0;
    status = INIT;
    wait_word(0, w, lat);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", {31'd0, valid, data}, {31'd0, 1'b1, 32'h40004000});
    end
    ready = 1'b1;
    check("overrun_set", {63'd0, overrun}, 64'd1);
    for (int i = 0; i < 12; i++) tick();

    // status leaves INIT mid-run, then returns
    status = 4'b0010;
    tick();
    check("drop_valid", {31'd0, valid, data}, 64'd0);
    check("overrun_sticky", {63'd0, overrun}, 64'd1);
    status = INIT;
    tick();
    check("overrun_clear", {63'd0, overrun}, 64'd0);
    wait_word(0, w, lat);
    check("restart_word", {32'd0, w}, {32'd0, 32'h40004000});

    // offset change mid-run realigns to phase 0
    for (int i = 0; i < 9; i++) tick();
    offset = 8'd8;
    wait_word(0, w, lat);
    check("realign_word", {32'd0, w}, {32'd0, 32'h4000C000});

    // asynchronous reset between edges mid-run
    for (int i = 0; i < 7; i++) tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", {29'd0, valid, sample, overrun, data}, 64'd0);
    model_reset();
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    wait_word(0, w, lat);
    check("post_reset_latency", 64'(lat), 64'd6);
    check("post_reset_word", {32'd0, w}, {32'd0, 32'h4000C000});

    // randomized traffic against the model
    status = INIT;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0)
        status = (status == INIT) ? 4'($urandom_range(0, 15)) : INIT;
      if ($urandom_range(0, 149) == 0)
        offset = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
